seq_signed_divider: RTL

- Iterative signed integer divider: the inverse datapath to the team's Booth multiply-accumulate block.
- Takes a DW-bit signed dividend (e.g. an accumulated MAC result) and a VW-bit signed divisor, one bit of quotient per clock.
- Produces quotient and remainder with truncate-toward-zero semantics.
- Valid/ready handshake on both input and output so it can sit behind the MAC stage or a CPU-side register interface.

---
 rtl/seq_signed_divider_if.sv | 27 ++
 rtl/seq_signed_divider.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// The master side supplies operands and accepts results; the slave side is the divider.
interface seq_signed_divider_if #(
    parameter int DW = 32,
    parameter int VW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Iterative radix-2 restoring signed divider, one quotient bit per clock.
// Quotient and remainder truncate toward zero; the remainder takes the dividend's sign.
module seq_signed_divider #(
    parameter int DW = 32,
    parameter int VW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_signed_divider_if.slave  bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] dq_r;
    logic [VW-1:0] rem_r;
    logic [VW-1:0] dvs_r;
    logic          sign_q_r;
    logic          sign_r_r;
    logic          ovf_case_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [DW-1:0] quotient_r;
    logic [VW-1:0] remainder_r;
    logic          div_by_zero_r;
    logic          overflow_r;

    logic          accept_s;
    logic          release_s;
    logic          div_zero_s;
    logic [DW-1:0] dividend_mag_s;
    logic [VW-1:0] divisor_mag_s;
    logic [VW:0]   shift_s;
    logic          ge_s;
    logic [VW-1:0] diff_s;

    // Handshake qualifiers, operand magnitudes and one restoring step
    always_comb begin
        accept_s       = bus.in_valid && in_ready_r && (state_r == IDLE);
        release_s      = out_valid_r && bus.out_ready;
        div_zero_s     = (bus.divisor == {VW{1'b0}});
        dividend_mag_s = bus.dividend[DW-1] ? ({DW{1'b0}} - bus.dividend) : bus.dividend;
        divisor_mag_s  = bus.divisor[VW-1] ? ({VW{1'b0}} - bus.divisor) : bus.divisor;
        shift_s        = {rem_r, dq_r[DW-1]};
        ge_s           = (shift_s >= {1'b0, dvs_r});
        // The remainder after subtraction is below |divisor|, so VW bits suffice
        diff_s         = shift_s[VW-1:0] - dvs_r;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = div_zero_s ? DONE : CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = CALC;
                end
            end
            FIX:     state_next_s = DONE;
            DONE: begin
                if (release_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath, result registers and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= {CW{1'b0}};
            dq_r          <= {DW{1'b0}};
            rem_r         <= {VW{1'b0}};
            dvs_r         <= {VW{1'b0}};
            sign_q_r      <= 1'b0;
            sign_r_r      <= 1'b0;
            ovf_case_r    <= 1'b0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            quotient_r    <= {DW{1'b0}};
            remainder_r   <= {VW{1'b0}};
            div_by_zero_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == IDLE);
            // out_valid trails entry into DONE by one edge
            out_valid_r <= (state_r == DONE) && !release_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dq_r       <= dividend_mag_s;
                        rem_r      <= {VW{1'b0}};
                        dvs_r      <= divisor_mag_s;
                        sign_q_r   <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
                        sign_r_r   <= bus.dividend[DW-1];
                        ovf_case_r <= (bus.dividend == {1'b1, {(DW-1){1'b0}}}) &&
                                      (bus.divisor == {VW{1'b1}});
                        cnt_r      <= CW'(DW-1);
                        if (div_zero_s) begin
                            quotient_r    <= {DW{1'b1}};
                            remainder_r   <= {VW{1'b0}};
                            div_by_zero_r <= 1'b1;
                            overflow_r    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    dq_r  <= {dq_r[DW-2:0], ge_s};
                    rem_r <= ge_s ? diff_s : shift_s[VW-1:0];
                    cnt_r <= cnt_r - CW'(1);
                end
                FIX: begin
                    quotient_r    <= sign_q_r ? ({DW{1'b0}} - dq_r) : dq_r;
                    remainder_r   <= sign_r_r ? ({VW{1'b0}} - rem_r) : rem_r;
                    overflow_r    <= ovf_case_r;
                    div_by_zero_r <= 1'b0;
                end
                DONE: begin
                    if (release_s) begin
                        quotient_r    <= {DW{1'b0}};
                        remainder_r   <= {VW{1'b0}};
                        div_by_zero_r <= 1'b0;
                        overflow_r    <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;
    assign bus.overflow    = overflow_r;
endmodule
